// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: picks one requester at a time and pushes its word
// into a FIFO, retrying through normal arbitration when the FIFO rejects it.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            wr_en,
  output logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            wr_ack,
  input  logic                            overflow,
  input  logic                            full,
  output logic                            busy,
  output logic [7:0]                      retry_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           last_q, last_d;
  logic [FIFO_WIDTH-1:0]   data_q, data_d;
  logic                    wr_en_q, wr_en_d;
  logic [7:0]              retry_q, retry_d;
  logic [NUM_REQ-1:0]      grant_s;
  logic [IW-1:0]           pick_s;
  logic                    accept_s;

  // First requester at or after last+1, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IW-1:0]      last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(last) + k) % NUM_REQ;
      pick  = (!found && r[idx]) ? IW'(idx) : pick;
      found = found | r[idx];
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(req, last_q);
  // A simultaneous overflow overrides an ack, so a rejected word is never granted.
  assign accept_s = wr_ack & ~overflow;

  // Next-state, capture and grant decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    retry_d = retry_q;
    grant_s = '0;
    case (state_q)
      IDLE: begin
        if ((|req) && !full) begin
          owner_d = pick_s;
          data_d  = req_data[int'(pick_s)*FIFO_WIDTH +: FIFO_WIDTH];
          wr_en_d = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (accept_s) begin
          grant_s[owner_q] = 1'b1;
          last_d           = owner_q;
        end else if (retry_q != 8'hFF) begin
          retry_d = retry_q + 8'd1;
        end else begin
          retry_d = retry_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      data_q  <= '0;
      wr_en_q <= 1'b0;
      retry_q <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      retry_q <= retry_d;
    end
  end

  // grant must land in the same cycle as wr_ack, so it is decoded, not registered.
  assign grant     = grant_s;
  assign wr_en     = wr_en_q;
  assign data_in   = data_q;
  assign busy      = (state_q != IDLE);
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference model.
module tb_fifo_wr_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     grant;
  logic             wr_en;
  logic [W-1:0]     data_in;
  logic             wr_ack;
  logic             overflow;
  logic             full;
  logic             busy;
  logic [7:0]       retry_cnt;

  logic [W-1:0]     tdata [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: phase 0 = idle, 1 = write on the bus, 2 = awaiting FIFO answer
  int           m_phase;
  int           m_owner;
  int           m_last;
  int           m_retry;
  logic [W-1:0] m_data;
  logic [N-1:0] g_last;
  int           gq[$];
  int           gcyc[$];

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
    .wr_en(wr_en), .data_in(data_in), .wr_ack(wr_ack), .overflow(overflow),
    .full(full), .busy(busy), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*W +: W] = tdata[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_retry = 0;
    m_data  = '0;
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic cycle(input logic [N-1:0] raise, input logic f, input logic a);
    logic [N-1:0] eg;
    int           idx;
    bit           found;
    req      = req | raise;
    full     = f;
    wr_ack   = a;
    overflow = a ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    eg = (m_phase == 2 && a) ? N'(1 << m_owner) : '0;
    chk("wr_en", wr_en, m_phase == 1);
    chk("busy", busy, m_phase != 0);
    chk("data_in", data_in, m_data);
    chk("grant", grant, eg);
    chk("retry_cnt", retry_cnt, m_retry);
    g_last = grant;
    if (eg != '0) begin
      gq.push_back(m_owner);
      gcyc.push_back(cyc);
    end
    req = req & ~eg;
    case (m_phase)
      0: begin
        if (req != '0 && !f) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && req[idx]) begin
              found   = 1'b1;
              m_owner = idx;
            end
          end
          m_data  = tdata[m_owner];
          m_phase = 1;
        end
      end
      1: m_phase = 2;
      default: begin
        if (a) m_last = m_owner;
        else if (m_retry < 255) m_retry++;
        m_phase = 0;
      end
    endcase
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    wr_ack   = 1'b0;
    overflow = 1'b0;
    full     = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data_in", data_in, '0);
    chk("rst_grant", grant, '0);
    chk("rst_retry_cnt", retry_cnt, 8'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gq.delete();
    gcyc.delete();
  endtask

  initial begin
    logic [N-1:0] r;
    logic         f;
    logic         a;
    rst_n    = 1'b0;
    req      = '0;
    wr_ack   = 1'b0;
    overflow = 1'b0;
    full     = 1'b0;
    for (int i = 0; i < N; i++) tdata[i] = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single requester, acked write
    tdata[0] = 16'hA5A5;
    cycle(4'b0001, 1'b0, 1'b0);
    chk("d1_wr_en", wr_en, 1'b1);
    chk("d1_data", data_in, 16'hA5A5);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    chk("d1_grant", g_last, 4'b0001);
    chk("d1_busy", busy, 1'b0);

    // all requesting, FIFO always acks
    do_reset();
    for (int i = 0; i < N; i++) tdata[i] = W'($urandom);
    repeat (15) cycle(4'b1111, 1'b0, 1'b1);
    chk("rr_count", gq.size(), 5);
    for (int k = 0; k < 5 && k < gq.size(); k++) chk("rr_order", gq[k], k % N);
    for (int k = 1; k < gcyc.size(); k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 3);

    // rejected write retries the same requester first
    do_reset();
    tdata[1] = 16'h1111;
    tdata[2] = 16'h2222;
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    chk("rj_first_grant", g_last, 4'b0010);
    cycle(4'b0110, 1'b0, 1'b0);
    chk("rj_data_2", data_in, 16'h2222);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("rj_retry", retry_cnt, 8'd1);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("rj_reissue_2", data_in, 16'h2222);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    chk("rj_grant_2", g_last, 4'b0100);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("rj_data_1", data_in, 16'h1111);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    chk("rj_grant_1", g_last, 4'b0010);

    // full stalls arbitration
    do_reset();
    tdata[3] = 16'h3C3C;
    repeat (10) cycle(4'b1000, 1'b1, 1'b0);
    chk("full_retry", retry_cnt, 8'd0);
    chk("full_no_wr", wr_en, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("full_release_wr", wr_en, 1'b1);
    chk("full_release_data", data_in, 16'h3C3C);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);

    // reset during ISSUE abandons the write
    do_reset();
    tdata[0] = 16'h5A5A;
    cycle(4'b0001, 1'b0, 1'b0);
    chk("rst_issue_wr", wr_en, 1'b1);
    do_reset();
    repeat (3) cycle(4'b0000, 1'b0, 1'b1);
    chk("rst_no_grant", gq.size(), 0);

    // saturation after 300 rejects
    repeat (900) cycle(4'b0001, 1'b0, 1'b0);
    chk("sat_retry", retry_cnt, 8'd255);

    // random traffic
    do_reset();
    repeat (3000) begin
      r = '0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          tdata[i] = W'($urandom);
          r[i]     = 1'b1;
        end
      end
      f = ($urandom_range(0, 4) == 0);
      a = ($urandom_range(0, 3) != 0);
      cycle(r, f, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: FIFO_WIDTH, default 16, width of each data word.
REQ-002 Parameter: NUM_REQ, default 4, number of requesters (2..8).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 Port: req  input  NUM_REQ  per-requester write request, held high until that requester's grant pulse.
REQ-006 Port: req_data  input  NUM_REQ*FIFO_WIDTH  requester i data in bits [i*FIFO_WIDTH +: FIFO_WIDTH], held stable while req[i] is high.
REQ-007 Port: grant  output  NUM_REQ  one-hot, one-cycle pulse: requester's word written to the FIFO.
REQ-008 Port: wr_en  output  1  FIFO write enable, registered.
REQ-009 Port: data_in  output  FIFO_WIDTH  FIFO write data, registered.
REQ-010 Port: wr_ack  input  1  FIFO write acknowledge, valid the cycle after wr_en.
REQ-011 Port: overflow  input  1  FIFO rejected-write flag, valid the cycle after wr_en.
REQ-012 Port: full  input  1  FIFO full flag.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: retry_cnt  output  8  saturating count of rejected writes.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_ACK; state register only.
REQ-016 IDLE: if any req bit high and full low, select the owner round-robin and capture its req_data into the data register, then go to ISSUE; otherwise stay in IDLE.
REQ-017 Round-robin: search starts at index (last_winner+1) mod NUM_REQ and proceeds upward with wrap; after reset last_winner = NUM_REQ-1, so requester 0 has first priority.
REQ-018 ISSUE: wr_en=1 and data_in=captured word for exactly one cycle; go to WAIT_ACK unconditionally.
REQ-019 WAIT_ACK: if wr_ack=1, pulse grant[owner] this cycle, set last_winner=owner, and go to IDLE.
REQ-020 WAIT_ACK: if wr_ack=0 (overflow or no ack), no grant; increment retry_cnt (saturate at 255); leave last_winner unchanged; go to IDLE.
REQ-021 A failed write therefore retries the same requester first if it still requests.
REQ-022 wr_en is 0 in IDLE and WAIT_ACK; at most one write is outstanding.
REQ-023 grant is 0 outside WAIT_ACK, and at most one bit is ever high.
REQ-024 Requests that drop after capture do not abort the write; the grant pulse is still issued on success.
REQ-025 full sampled high in IDLE stalls arbitration with no wr_en and no retry count.
REQ-026 Peak throughput: one word per 3 cycles (IDLE, ISSUE, WAIT_ACK).
REQ-027 data_in holds its last value when wr_en is 0.

Reset
REQ-028 When rst_n=0 (asynchronous): state=IDLE, wr_en=0, data_in=0, grant=0, busy=0, retry_cnt=0, last_winner=NUM_REQ-1.
REQ-029 Reset asserted during ISSUE or WAIT_ACK abandons the transaction: no grant and no retry increment.
REQ-030 The first arbitration occurs on the first rising edge after rst_n deasserts.

Verification
REQ-031 req=4'b0001, data0=16'hA5A5, wr_ack=1 in WAIT_ACK -> wr_en high for 1 cycle with data_in=16'hA5A5, grant=4'b0001 two cycles later, busy back to 0.
REQ-032 req=4'b1111 held, FIFO always acks -> grant order 0,1,2,3,0 with one grant every 3 cycles.
REQ-033 req=4'b0110 with last_winner=1 and FIFO returning overflow (wr_ack=0) on the first write -> retry_cnt=1 and requester 2 is reissued next; on its ack, grant=4'b0100, then requester 1.
REQ-034 full=1 with req=4'b1000 for 10 cycles -> no wr_en and retry_cnt unchanged; full drops -> write issued within 1 cycle.
REQ-035 rst_n pulled low in ISSUE -> outputs go to reset values immediately, no grant; 300 forced rejects -> retry_cnt saturates at 255.
